// File: rtl/mux_n_in_skid_if.sv
// Handshake bundle for mux_n_in_skid.
// Upstream side : data_i (N_INPUTS packed operands), sel_i, valid_i, ready_o, flush_i.
// Downstream side: data_o, sel_err_o, valid_o, ready_i, err_cnt_o.
// slave modport is the block's view; master modport is the driver/sink view.
interface mux_n_in_skid_if #(
    parameter int NB_DATA   = 32,
    parameter int N_INPUTS  = 4,
    parameter int NB_SEL    = 2,
    parameter int NB_ERRCNT = 8
);
    logic [N_INPUTS*NB_DATA-1:0] data_i;
    logic [NB_SEL-1:0]           sel_i;
    logic                        valid_i;
    logic                        ready_o;
    logic                        flush_i;
    logic [NB_DATA-1:0]          data_o;
    logic                        sel_err_o;
    logic                        valid_o;
    logic                        ready_i;
    logic [NB_ERRCNT-1:0]        err_cnt_o;

    modport slave (
        input  data_i, sel_i, valid_i, flush_i, ready_i,
        output ready_o, data_o, sel_err_o, valid_o, err_cnt_o
    );

    modport master (
        output data_i, sel_i, valid_i, flush_i, ready_i,
        input  ready_o, data_o, sel_err_o, valid_o, err_cnt_o
    );
endinterface

// File: rtl/mux_n_in_skid.sv
// N-input registered operand multiplexer with a 2-entry skid buffer.
// Ports:
//   clock_i : clock, all state on rising edge
//   reset_i : asynchronous active-low reset
//   bus     : mux_n_in_skid_if.slave
//             data_i/sel_i/valid_i/ready_o/flush_i  upstream side
//             data_o/sel_err_o/valid_o/ready_i      downstream side
//             err_cnt_o  saturating count of accepted out-of-range selects
// Selection is combinational; only the selected word is registered.
// Out-of-range selects fall back to operand DEFAULT_IDX and are flagged.
module mux_n_in_skid #(
    parameter int NB_DATA     = 32,
    parameter int N_INPUTS    = 4,
    parameter int NB_SEL      = 2,
    parameter int DEFAULT_IDX = 0,
    parameter int NB_ERRCNT   = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    mux_n_in_skid_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    state_t               state;
    logic [NB_DATA-1:0]   out_data;
    logic                 out_err;
    logic                 out_valid;
    logic [NB_DATA-1:0]   skid_data;
    logic                 skid_err;
    logic                 skid_valid;
    logic [NB_ERRCNT-1:0] err_cnt;

    logic [NB_DATA-1:0]   sel_data;
    logic                 sel_err;
    logic                 accept;
    logic                 consume;

    // Loop compare keeps the select width independent of N_INPUTS.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int unsigned k = 0; k < N_INPUTS; k++) begin
            if (bus.sel_i == NB_SEL'(k)) begin
                sel_data = bus.data_i[k*NB_DATA +: NB_DATA];
                sel_err  = 1'b0;
            end
        end
        if (sel_err) begin
            sel_data = bus.data_i[DEFAULT_IDX*NB_DATA +: NB_DATA];
        end
    end

    // ready_o is !skid_valid, a register, so there is no path from ready_i.
    always_comb begin
        accept  = bus.valid_i && !skid_valid;
        consume = out_valid && bus.ready_i;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state      <= ST_EMPTY;
            out_data   <= '0;
            out_err    <= 1'b0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
            skid_valid <= 1'b0;
            err_cnt    <= '0;
        end else if (bus.flush_i) begin
            // out_data/out_err are left as-is; only the valid flags drop.
            state      <= ST_EMPTY;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (accept && sel_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + NB_ERRCNT'(1);
            end
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_data  <= sel_data;
                        out_err   <= sel_err;
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        out_data <= sel_data;
                        out_err  <= sel_err;
                    end else if (accept) begin
                        skid_data  <= sel_data;
                        skid_err   <= sel_err;
                        skid_valid <= 1'b1;
                        state      <= ST_TWO;
                    end else if (consume) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // accept cannot happen here: ready_o is low while SKID is full.
                    if (consume) begin
                        out_data   <= skid_data;
                        out_err    <= skid_err;
                        skid_valid <= 1'b0;
                        state      <= ST_ONE;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    out_valid  <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_o    = out_data;
    assign bus.sel_err_o = out_err;
    assign bus.valid_o   = out_valid;
    assign bus.ready_o   = !skid_valid;
    assign bus.err_cnt_o = err_cnt;

endmodule

// File: doc/mux_n_in_skid.md
Name: mux_n_in_skid

Overview:
- Parametrised N-input registered operand multiplexer; successor to the combinational 3-input mux used in the datapath.
- Selects one of N_INPUTS packed operands and registers the result behind a valid/ready handshake, with a 2-entry skid buffer so stalls never drop data.
- Adds flush, out-of-range select detection and an error counter.
- Intended for pipeline-stage operand selection (forwarding / ALU source) where downstream can stall.

Parameters:
- NB_DATA, 32, width of each operand and of data_o.
- N_INPUTS, 4, number of operands (2..16).
- NB_SEL, 2, select width; must satisfy 2**NB_SEL >= N_INPUTS.
- DEFAULT_IDX, 0, operand index used when sel_i >= N_INPUTS.
- NB_ERRCNT, 8, width of the out-of-range event counter.

Ports:
- clock_i  in  1  clock, all state on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- data_i  in  N_INPUTS*NB_DATA  packed operands; operand k = data_i[k*NB_DATA +: NB_DATA].
- sel_i  in  NB_SEL  operand select, sampled with valid_i.
- valid_i  in  1  upstream word valid.
- ready_o  out  1  block can accept a word this cycle.
- flush_i  in  1  synchronous discard of all buffered words.
- data_o  out  NB_DATA  selected, registered operand.
- sel_err_o  out  1  word on data_o was produced from an out-of-range select.
- valid_o  out  1  data_o/sel_err_o valid.
- ready_i  in  1  downstream accepts data_o this cycle.
- err_cnt_o  out  NB_ERRCNT  saturating count of accepted out-of-range selects.

Behaviour:
- Reset (reset_i=0, async): valid_o=0, data_o=0, sel_err_o=0, ready_o=1, skid empty, err_cnt_o=0.
- Selection: sel_i < N_INPUTS picks operand sel_i, sel_err=0; otherwise picks operand DEFAULT_IDX, sel_err=1. Selection is combinational; only the result is registered.
- Accept: a word is taken when valid_i && ready_o. Consume: a word leaves when valid_o && ready_i.
- Storage: output register (OUT) plus one skid register (SKID). Each holds data and sel_err.
- ready_o = !skid_valid. It is a registered value; no combinational path from ready_i.
- On accept:
  - If OUT is empty or being consumed, the word goes to OUT.
  - Otherwise it goes to SKID.
- On consume with SKID full: SKID moves to OUT and SKID empties.
- Simultaneous consume + SKID full + accept cannot occur, because ready_o=0 while SKID is full.
- Latency: 1 cycle from accept to valid_o when OUT is free. Throughput is 1 word/cycle while ready_i=1.
- Holding: data_o and sel_err_o are stable while valid_o && !ready_i.
- States (by occupancy):
  - EMPTY: accept -> ONE.
  - ONE:
    - accept && !consume -> TWO.
    - consume && !accept -> EMPTY.
    - both or neither -> ONE.
  - TWO: consume -> ONE.
- Flush: flush_i=1 sets valid_o=0 and SKID empty next edge and returns the block to EMPTY.
  - Any word presented that cycle is dropped and not counted.
  - data_o keeps its old value.
  - Flush overrides accept and consume.
- err_cnt_o: increments by 1 on each accepted word with sel_err=1 and saturates at all-ones. Flush does not clear it; only reset does.
- Reset mid-operation clears all buffered words immediately, regardless of the clock.

Test Plan:
- N_INPUTS=4, operands 0x11,0x22,0x33,0x44, sel_i=2, valid_i=1, ready_i=1 -> next cycle data_o=0x33, valid_o=1, sel_err_o=0; streaming sel 0,1,3 gives 0x11,0x22,0x44 on consecutive cycles.
- N_INPUTS=3, DEFAULT_IDX=0, sel_i=3 -> data_o=op0, sel_err_o=1, err_cnt_o=1; repeat 300 times with NB_ERRCNT=8 -> err_cnt_o saturates at 255.
- ready_i=0, send words A,B -> valid_o=1, data_o=A, ready_o=0 after B; C is held off; raise ready_i -> A, B, C emerge in order with no loss or duplicate.
- Words in OUT and SKID, assert flush_i with valid_i=1 -> next cycle valid_o=0, ready_o=1, and the flushed and in-flight words never appear.
- Assert reset_i=0 asynchronously mid-stream, between clock edges -> valid_o, sel_err_o, data_o, err_cnt_o go to 0 and ready_o to 1 immediately.
- Random valid_i/ready_i/sel_i over 10k cycles against a reference queue model -> output order and values match and data_o is stable under backpressure.
